// File: rtl/alu_result_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_result_stage_if : operation input and result output bundle for       |
// |                       alu_result_stage                                   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface alu_result_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [DATA_WIDTH-1:0] in_a_plus_b;
  logic [DATA_WIDTH-1:0] in_a_minus_b;
  logic [DATA_WIDTH-1:0] in_not_a;
  logic [DATA_WIDTH-1:0] in_a_and_b;
  logic [DATA_WIDTH-1:0] in_a_or_b;
  logic [DATA_WIDTH-1:0] in_a_xor_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [3:0]            out_flags;
  logic                  out_err;

  // Upstream/consumer side of the stage
  modport master (
    output in_valid, in_op, in_a, in_b,
    output in_a_plus_b, in_a_minus_b, in_not_a, in_a_and_b, in_a_or_b, in_a_xor_b,
    output out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_err
  );

  // The stage itself
  modport slave (
    input  in_valid, in_op, in_a, in_b,
    input  in_a_plus_b, in_a_minus_b, in_not_a, in_a_and_b, in_a_or_b, in_a_xor_b,
    input  out_ready,
    output in_ready, out_valid, out_result, out_flags, out_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_result_stage : selects an ALU result by opcode, derives Z/N/C/V and  |
// |                    holds it in a 2-entry valid/ready output buffer       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_result_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  alu_result_stage_if.slave bus
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_result_q, head_result_d;
  logic [3:0]            head_flags_q, head_flags_d;
  logic                  head_err_q, head_err_d;
  logic [DATA_WIDTH-1:0] tail_result_q, tail_result_d;
  logic [3:0]            tail_flags_q, tail_flags_d;
  logic                  tail_err_q, tail_err_d;

  logic [DATA_WIDTH-1:0] new_result;
  logic                  new_err;
  logic                  new_c;
  logic                  new_v;
  logic [3:0]            new_flags;
  logic                  push;
  logic                  pop;

  // Handshake depends only on registered occupancy, never on out_ready.
  assign bus.in_ready   = (count_q != CNT_FULL);
  assign bus.out_valid  = (count_q != CNT_EMPTY);
  assign bus.out_result = head_result_q;
  assign bus.out_flags  = head_flags_q;
  assign bus.out_err    = head_err_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    new_result = '0;
    new_err    = 1'b0;
    case (bus.in_op)
      OP_ADD:  new_result = bus.in_a_plus_b;
      OP_SUB:  new_result = bus.in_a_minus_b;
      OP_NOT:  new_result = bus.in_not_a;
      OP_AND:  new_result = bus.in_a_and_b;
      OP_OR:   new_result = bus.in_a_or_b;
      OP_XOR:  new_result = bus.in_a_xor_b;
      default: new_err    = 1'b1;
    endcase
  end

  // Carry/overflow are inferred from operand and result sign bits, so the
  // supplied sum/difference is trusted rather than recomputed.
  always_comb begin
    new_c = 1'b0;
    new_v = 1'b0;
    case (bus.in_op)
      OP_ADD: begin
        new_c = (bus.in_a[MSB] & bus.in_b[MSB]) |
                ((bus.in_a[MSB] | bus.in_b[MSB]) & ~new_result[MSB]);
        new_v = (bus.in_a[MSB] == bus.in_b[MSB]) & (new_result[MSB] != bus.in_a[MSB]);
      end
      OP_SUB: begin
        new_c = (bus.in_a < bus.in_b);
        new_v = (bus.in_a[MSB] != bus.in_b[MSB]) & (new_result[MSB] != bus.in_a[MSB]);
      end
      default: begin
        new_c = 1'b0;
        new_v = 1'b0;
      end
    endcase
  end

  assign new_flags = {(new_result == '0), new_result[MSB], new_c, new_v};

  always_comb begin
    count_d       = count_q;
    head_result_d = head_result_q;
    head_flags_d  = head_flags_q;
    head_err_d    = head_err_q;
    tail_result_d = tail_result_q;
    tail_flags_d  = tail_flags_q;
    tail_err_d    = tail_err_q;
    case (count_q)
      CNT_EMPTY: begin
        if (push) begin
          head_result_d = new_result;
          head_flags_d  = new_flags;
          head_err_d    = new_err;
          count_d       = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (push && pop) begin
          head_result_d = new_result;
          head_flags_d  = new_flags;
          head_err_d    = new_err;
        end else if (push) begin
          tail_result_d = new_result;
          tail_flags_d  = new_flags;
          tail_err_d    = new_err;
          count_d       = CNT_FULL;
        end else if (pop) begin
          // Head keeps its contents so outputs hold while empty.
          count_d = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        if (pop) begin
          head_result_d = tail_result_q;
          head_flags_d  = tail_flags_q;
          head_err_d    = tail_err_q;
          count_d       = CNT_ONE;
        end
      end
      default: count_d = CNT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q       <= CNT_EMPTY;
      head_result_q <= '0;
      head_flags_q  <= '0;
      head_err_q    <= 1'b0;
      tail_result_q <= '0;
      tail_flags_q  <= '0;
      tail_err_q    <= 1'b0;
    end else begin
      count_q       <= count_d;
      head_result_q <= head_result_d;
      head_flags_q  <= head_flags_d;
      head_err_q    <= head_err_d;
      tail_result_q <= tail_result_d;
      tail_flags_q  <= tail_flags_d;
      tail_err_q    <= tail_err_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered downstream stage for the combinational basic ALU.
- Takes operands a/b, a 3-bit opcode and the six parallel ALU results; selects one result by opcode and computes Z/N/C/V status flags.
- Holds results in a 2-entry output buffer behind a valid/ready handshake.
- Decouples the ALU's combinational cone from the writeback/consumer path. There is no combinational path from out_ready to in_ready.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has an operation this cycle
- in_ready  output  1  stage can accept this cycle
- in_op  input  3  0=ADD 1=SUB 2=NOT 3=AND 4=OR 5=XOR 6,7=illegal
- in_a  input  DATA_WIDTH  operand a (flag computation only)
- in_b  input  DATA_WIDTH  operand b (flag computation only)
- in_a_plus_b, in_a_minus_b, in_not_a, in_a_and_b, in_a_or_b, in_a_xor_b  input  DATA_WIDTH each  ALU results
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head this cycle
- out_result  output  DATA_WIDTH  selected result
- out_flags  output  4  {Z,N,C,V}
- out_err  output  1  illegal opcode marker

Behaviour:
- Reset (resetn low, asynchronous assert, synchronous-to-clk deassert):
  - buffer count=0, out_valid=0, out_result=0, out_flags=0, out_err=0, in_ready=1.
  - Reset mid-operation discards all buffered entries immediately.
- Handshake and buffer:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != 2). It is a function of registered count only.
  - out_valid = (count != 0). The head entry drives out_result/out_flags/out_err.
  - When count=0, outputs hold their last values.
  - count=0, push → count 1; head visible the next cycle (latency 1).
  - count=1, push & pop same cycle → count stays 1; the new entry becomes head the next cycle.
  - count=2: no push is possible; pop → count 1, second entry promoted to head.
  - Head and out_* are stable while out_valid=1 and out_ready=0.
  - in_* are ignored when push=0.
  - Entries leave in strict FIFO order. No drops, no duplicates.
- Result selection by opcode:
  - 0 → in_a_plus_b; 1 → in_a_minus_b; 2 → in_not_a; 3 → in_a_and_b; 4 → in_a_or_b; 5 → in_a_xor_b.
  - 6/7 → result 0, err=1, flags Z=1 and N=C=V=0.
- Flags (M = DATA_WIDTH-1, r = selected result), all computed at push time:
  - Z = (r == 0). N = r[M].
  - ADD: C = (a[M]&b[M]) | ((a[M]|b[M]) & ~r[M]). V = (a[M]==b[M]) & (r[M]!=a[M]).
  - SUB: C = borrow = (a < b unsigned). V = (a[M]!=b[M]) & (r[M]!=a[M]).
  - Logic ops: C=0, V=0.
- All arithmetic is modulo 2^DATA_WIDTH. The stage trusts the supplied results and does not recompute them.

Test Plan (DATA_WIDTH=8 unless noted):
- Reset then ADD a=0xFF, b=0x01, sum=0x00, out_ready=1 → next cycle out_valid=1, result 0x00, flags Z=1 N=0 C=1 V=0, err=0.
- ADD a=0x7F, b=0x01, sum=0x80 → result 0x80, Z=0 N=1 C=0 V=1. SUB a=0x80, b=0x01, diff=0x7F → N=0 C=0 V=1. SUB a=0x01, b=0x02, diff=0xFF → N=1 C=1 V=0.
- out_ready=0; push three ops (XOR 0x0F, OR 0xF0, AND 0x00) on back-to-back cycles:
  - in_ready drops to 0 after the second push; the third op is held by the upstream.
  - Raising out_ready drains 0x0F, 0xF0, 0x00 in order; Z=1 only on the last.
- Streaming: in_valid=1 and out_ready=1 continuously with NOT over a=0..9 → one result per cycle (0xFF..0xF6), in_ready never drops, count stays 1.
- in_op=6 and 7 → result 0, err=1, flags {Z,N,C,V}=4'b1000; the next legal op clears err.
- Two entries buffered, resetn pulsed low mid-cycle → out_valid=0 and in_ready=1 immediately without a clock edge; no stale entry appears after release.
